time_set_controller: RTL and testbench

Sequences user time and alarm entry for the alarm clock. It collects four BCD keypad digits, checks that they form a legal HH:MM value, and then does one of two things. For a time entry it drives a one-cycle `set_time` load with `new_time` into the counting logic. For an alarm entry it latches the value into the alarm register. It sits between the keypad/button debouncers and the counting logic, and it also supplies the entry buffer and mode flags to the display mux.

---
 rtl/time_set_controller.sv | 163 ++++++++++++++++
 tb/tb_time_set_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// time_set_controller
//   Collects four BCD keypad digits as an HH:MM entry for either the clock
//   time or the alarm. It checks that the entry is a legal time. A legal time
//   entry produces a one-cycle set_time load with new_time. A legal alarm
//   entry is latched into alarm_time. An illegal entry produces a one-cycle
//   error strobe. All outputs are registered.
//
// Ports
//   clk, reset        : single clock; synchronous active-high reset
//   key_valid         : one-cycle strobe qualifying key_digit
//   key_digit [3:0]   : BCD digit from the keypad (values > 9 are discarded)
//   time_btn          : one-cycle press; starts or cancels a time entry
//   alarm_btn         : one-cycle press; starts or cancels an alarm entry
//   set_time          : one-cycle load strobe to the counting logic
//   new_time [15:0]   : BCD HH:MM load value, held until the next time load
//   alarm_time [15:0] : stored BCD alarm value
//   entry_buf [15:0]  : digits entered so far, right-justified
//   entry_active      : high while collecting or validating an entry
//   entry_target      : 0 = time entry, 1 = alarm entry (sticky)
//   error             : one-cycle strobe when a completed entry is rejected
module time_set_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        time_btn,
    input  logic        alarm_btn,
    output logic        set_time,
    output logic [15:0] new_time,
    output logic [15:0] alarm_time,
    output logic [15:0] entry_buf,
    output logic        entry_active,
    output logic        entry_target,
    output logic        error
);

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_VALIDATE, S_LOAD} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [2:0]  digit_cnt, digit_cnt_nx;
    logic [15:0] tmo_cnt, tmo_cnt_nx;

    logic        set_time_nx, error_nx, entry_active_nx, entry_target_nx;
    logic [15:0] new_time_nx, alarm_time_nx, entry_buf_nx;

    logic        cancel, digit_ok, timed_out, entry_legal;
    logic [6:0]  hours, minutes;

    // Two BCD digits to binary; 7 bits suffice because both digits are <= 9.
    function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    // Only the button matching the current target cancels an entry.
    assign cancel      = entry_target ? alarm_btn : time_btn;
    assign digit_ok    = key_valid && (key_digit <= 4'd9);
    assign timed_out   = (tmo_cnt == TMO_LAST);
    assign hours       = bcd_pair(entry_buf[15:12], entry_buf[11:8]);
    assign minutes     = bcd_pair(entry_buf[7:4], entry_buf[3:0]);
    assign entry_legal = (hours < 7'd24) && (minutes < 7'd60);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            digit_cnt    <= '0;
            tmo_cnt      <= '0;
            set_time     <= 1'b0;
            error        <= 1'b0;
            entry_active <= 1'b0;
            entry_target <= 1'b0;
            new_time     <= '0;
            alarm_time   <= '0;
            entry_buf    <= '0;
        end else begin
            state        <= state_nx;
            digit_cnt    <= digit_cnt_nx;
            tmo_cnt      <= tmo_cnt_nx;
            set_time     <= set_time_nx;
            error        <= error_nx;
            entry_active <= entry_active_nx;
            entry_target <= entry_target_nx;
            new_time     <= new_time_nx;
            alarm_time   <= alarm_time_nx;
            entry_buf    <= entry_buf_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (time_btn || alarm_btn) state_nx = S_ENTER;
            end
            S_ENTER: begin
                // Cancel and timeout both take priority over a digit.
                if (cancel || timed_out)                   state_nx = S_IDLE;
                else if (digit_ok && digit_cnt == 3'd3)    state_nx = S_VALIDATE;
            end
            S_VALIDATE: state_nx = entry_legal ? S_LOAD : S_IDLE;
            S_LOAD:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        digit_cnt_nx    = digit_cnt;
        tmo_cnt_nx      = tmo_cnt;
        set_time_nx     = 1'b0;
        error_nx        = 1'b0;
        entry_target_nx = entry_target;
        new_time_nx     = new_time;
        alarm_time_nx   = alarm_time;
        entry_buf_nx    = entry_buf;
        entry_active_nx = (state_nx == S_ENTER) || (state_nx == S_VALIDATE);
        case (state)
            S_IDLE: begin
                if (time_btn || alarm_btn) begin
                    // Time entry wins when both buttons arrive together.
                    entry_target_nx = !time_btn;
                    entry_buf_nx    = '0;
                    digit_cnt_nx    = '0;
                    tmo_cnt_nx      = '0;
                end
            end
            S_ENTER: begin
                if (!(cancel || timed_out)) begin
                    if (digit_ok) begin
                        entry_buf_nx = {entry_buf[11:0], key_digit};
                        digit_cnt_nx = digit_cnt + 3'd1;
                        tmo_cnt_nx   = '0;
                    end else begin
                        // Discarded digits do not restart the idle timer.
                        tmo_cnt_nx = tmo_cnt + 16'd1;
                    end
                end
            end
            S_VALIDATE: begin
                // Load registers update here so the value is already stable
                // in the cycle where set_time is high.
                if (entry_legal) begin
                    if (!entry_target) begin
                        set_time_nx = 1'b1;
                        new_time_nx = entry_buf;
                    end else begin
                        alarm_time_nx = entry_buf;
                    end
                end else begin
                    error_nx     = 1'b1;
                    entry_buf_nx = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset, key_valid, time_btn, alarm_btn;
    logic [3:0]  key_digit;
    logic        set_time, entry_active, entry_target, error;
    logic [15:0] new_time, alarm_time, entry_buf;

    time_set_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
        .time_btn(time_btn), .alarm_btn(alarm_btn), .set_time(set_time),
        .new_time(new_time), .alarm_time(alarm_time), .entry_buf(entry_buf),
        .entry_active(entry_active), .entry_target(entry_target), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an entry is a list of accepted digits plus an idle
    // count; a completed list is judged one cycle later and its result is
    // visible for exactly one cycle.
    bit          m_in_entry;
    bit          m_tgt;
    int          m_digs[$];
    int          m_idle;
    int          m_phase;   // 0 none, 1 judging, 2 result showing
    logic        e_set, e_err, e_act, e_tgt;
    logic [15:0] e_new, e_alarm, e_buf;

    function automatic logic [15:0] pack_digits();
        int v = 0;
        foreach (m_digs[i]) v = v * 16 + m_digs[i];
        return 16'(v);
    endfunction

    task automatic model_reset();
        m_in_entry = 0; m_tgt = 0; m_digs.delete(); m_idle = 0; m_phase = 0;
        e_set = 0; e_err = 0; e_act = 0; e_tgt = 0;
        e_new = 0; e_alarm = 0; e_buf = 0;
    endtask

    task automatic model_step(input bit kv, input int kd, input bit tb, input bit ab);
        int hh, mm;
        e_set = 0;
        e_err = 0;
        if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            hh = m_digs[0] * 10 + m_digs[1];
            mm = m_digs[2] * 10 + m_digs[3];
            if (hh < 24 && mm < 60) begin
                if (!m_tgt) begin e_set = 1; e_new = pack_digits(); end
                else        e_alarm = pack_digits();
                m_phase = 2;
            end else begin
                e_err = 1;
                m_digs.delete();
                m_phase = 0;
            end
        end else if (!m_in_entry) begin
            if (tb || ab) begin
                m_in_entry = 1; m_tgt = !tb; m_digs.delete(); m_idle = 0;
            end
        end else begin
            if ((m_tgt ? ab : tb) || m_idle == T - 1) begin
                m_in_entry = 0;
            end else if (kv && kd <= 9) begin
                m_digs.push_back(kd);
                m_idle = 0;
                if (m_digs.size() == 4) begin m_in_entry = 0; m_phase = 1; end
            end else begin
                m_idle++;
            end
        end
        e_act = m_in_entry || (m_phase == 1);
        e_tgt = m_tgt;
        e_buf = pack_digits();
    endtask

    task automatic compare_all();
        check("set_time",     16'(set_time),     16'(e_set));
        check("error",        16'(error),        16'(e_err));
        check("entry_active", 16'(entry_active), 16'(e_act));
        check("entry_target", 16'(entry_target), 16'(e_tgt));
        check("new_time",     new_time,          e_new);
        check("alarm_time",   alarm_time,        e_alarm);
        check("entry_buf",    entry_buf,         e_buf);
        check("set_and_err",  16'(set_time & error), 16'h0);
    endtask

    task automatic tick(input bit rst, input bit kv, input int kd, input bit tb, input bit ab);
        reset = rst; key_valid = kv; key_digit = 4'(kd); time_btn = tb; alarm_btn = ab;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(kv, kd, tb, ab);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic key(input int d);
        tick(0, 1, d, 0, 0);
    endtask

    task automatic enter4(input bit alarm, input int a, input int b, input int c, input int d);
        tick(0, 0, 0, !alarm, alarm);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        int quiet;
        int r;
        bit kv;
        reset = 1; key_valid = 0; key_digit = 0; time_btn = 0; alarm_btn = 0;
        model_reset();

        tick(1, 0, 0, 0, 0);
        check("rst_new_time", new_time, 16'h0000);
        check("rst_active",   16'(entry_active), 16'h0);

        // Time entry 12:34: set_time two cycles after the 4th digit.
        enter4(0, 1, 2, 3, 4);
        check("validate_no_set", 16'(set_time), 16'h0);
        idle(1);
        check("t1234_set",  16'(set_time), 16'h1);
        check("t1234_new",  new_time, 16'h1234);
        idle(1);
        check("t1234_set_off", 16'(set_time), 16'h0);
        check("t1234_held", new_time, 16'h1234);
        check("t1234_alarm", alarm_time, 16'h0000);
        check("t1234_inact", 16'(entry_active), 16'h0);

        // Alarm 06:30 then time 23:59.
        enter4(1, 0, 6, 3, 0);
        idle(1);
        check("a0630_noset", 16'(set_time), 16'h0);
        idle(1);
        check("a0630_alarm", alarm_time, 16'h0630);
        enter4(0, 2, 3, 5, 9);
        idle(2);
        check("t2359_new", new_time, 16'h2359);

        // Illegal hours and illegal minutes.
        enter4(0, 2, 4, 0, 0);
        idle(1);
        check("e2400_err", 16'(error), 16'h1);
        idle(1);
        check("e2400_new", new_time, 16'h2359);
        enter4(0, 1, 2, 6, 0);
        idle(1);
        check("e1260_err", 16'(error), 16'h1);
        idle(1);

        // Illegal digit dropped; cancel after two digits.
        tick(0, 0, 0, 1, 0);
        key(1); key(10); key(2); key(3); key(4);
        idle(2);
        check("drop_a_new", new_time, 16'h1234);
        tick(0, 0, 0, 1, 0);
        key(5); key(6);
        tick(0, 0, 0, 0, 1);   // other target: ignored
        check("other_btn_active", 16'(entry_active), 16'h1);
        tick(0, 0, 0, 1, 0);
        check("cancel_inactive", 16'(entry_active), 16'h0);
        idle(3);
        check("cancel_no_load", new_time, 16'h1234);

        // Timeout after one digit, then slow but in-time entry.
        tick(0, 0, 0, 1, 0);
        key(1);
        idle(6);
        check("tmo_still_active", 16'(entry_active), 16'h1);
        idle(2);
        check("tmo_aborted", 16'(entry_active), 16'h0);
        idle(2);
        tick(0, 0, 0, 1, 0);
        idle(6); key(0);
        idle(6); key(9);
        idle(6); key(4);
        idle(6); key(5);
        idle(1);
        check("slow_set", 16'(set_time), 16'h1);
        check("slow_new", new_time, 16'h0945);
        idle(1);

        // Reset mid-entry.
        tick(0, 0, 0, 1, 0);
        key(1); key(2); key(3);
        tick(1, 0, 0, 0, 0);
        check("mid_rst_new",   new_time, 16'h0000);
        check("mid_rst_alarm", alarm_time, 16'h0000);
        check("mid_rst_buf",   entry_buf, 16'h0000);
        key(4);
        idle(3);
        check("mid_rst_noload", new_time, 16'h0000);

        // Randomized traffic against the model.
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 59) == 0) quiet = $urandom_range(5, 14);
            kv = (quiet == 0) && ($urandom_range(0, 99) < 45);
            tick(r == 0, kv, $urandom_range(0, 11), r inside {[1:6]}, r inside {[5:10]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
